// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - demand-driven round-robin phase scheduler for a four-way intersection
// Emergency preemption is built only when EMERGENCY_PREEMPT_EN is defined.
module traffic_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int TW        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       emg_req,
    input  logic [1:0] emg_dir,
    output logic [1:0] n_lights,
    output logic [1:0] e_lights,
    output logic [1:0] s_lights,
    output logic [1:0] w_lights,
    output logic [1:0] grant_dir,
    output logic [1:0] phase
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_GREEN  = 2'b01,
        S_YELLOW = 2'b10,
        S_ALLRED = 2'b11
    } state_t;

    localparam logic [TW-1:0] GMIN_LAST = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_LAST = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(ALLRED_T - 1);
    localparam logic [1:0]    LT_YELLOW = 2'b01;
    localparam logic [1:0]    LT_GREEN  = 2'b10;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    grant_q, grant_d;
    logic [7:0]    lights_q, lights_d;
    logic [1:0]    rr_win, pick_dir;
    logic          pick_valid, other_dem, own_req, emg_hold, emg_cut;

    // First set bit scanning upward from p+1; p itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] idx;
        w = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    assign rr_win    = rr_pick(req, ptr_q);
    assign other_dem = |(req & ~(4'b0001 << grant_q));
    assign own_req   = req[grant_q];
    assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;

`ifdef EMERGENCY_PREEMPT_EN
    always_comb begin
        pick_valid = |req | emg_req;
        pick_dir   = emg_req ? emg_dir : rr_win;
        emg_hold   = emg_req && (emg_dir == grant_q);
        emg_cut    = emg_req && (emg_dir != grant_q);
    end
`else
    logic unused_emg;
    assign unused_emg = ^{emg_req, emg_dir};
    always_comb begin
        pick_valid = |req;
        pick_dir   = rr_win;
        emg_hold   = 1'b0;
        emg_cut    = 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_GREEN;
                    grant_d = pick_dir;
                    ptr_d   = pick_dir;
                    timer_d = '0;
                end
            end
            S_GREEN: begin
                timer_d = timer_inc;
                // timer_q counts completed green cycles minus one.
                if (emg_cut || (!emg_hold && other_dem &&
                    ((!own_req && timer_q >= GMIN_LAST) || timer_q >= GMAX_LAST))) begin
                    state_d = S_YELLOW;
                    timer_d = '0;
                end
            end
            S_YELLOW: begin
                timer_d = timer_inc;
                if (timer_q == YEL_LAST) begin
                    state_d = S_ALLRED;
                    timer_d = '0;
                end
            end
            default: begin
                timer_d = timer_inc;
                if (timer_q == AR_LAST) begin
                    timer_d = '0;
                    if (pick_valid) begin
                        state_d = S_GREEN;
                        grant_d = pick_dir;
                        ptr_d   = pick_dir;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        lights_d = '0;
        if (state_d == S_GREEN)  lights_d[{grant_d, 1'b0} +: 2] = LT_GREEN;
        if (state_d == S_YELLOW) lights_d[{grant_d, 1'b0} +: 2] = LT_YELLOW;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            ptr_q    <= 2'd3;
            grant_q  <= 2'd0;
            lights_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            lights_q <= lights_d;
        end
    end

    assign n_lights  = lights_q[1:0];
    assign e_lights  = lights_q[3:2];
    assign s_lights  = lights_q[5:4];
    assign w_lights  = lights_q[7:6];
    assign grant_dir = grant_q;
    assign phase     = state_q;
endmodule
